// File: rtl/cpu_trace_if.sv
// Trace bus between a CPU commit port / trace consumer and cpu_trace_monitor.
// master drives commits and pops; slave (the monitor) returns the FIFO head.
interface cpu_trace_if #(
    parameter int unsigned DATA_W = 32
);
    logic              commit_valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              reg_write;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;

    logic              rd_en;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_inst;
    logic              rd_we;
    logic [4:0]        rd_wreg;
    logic [DATA_W-1:0] rd_wdata;

    modport master (
        output commit_valid, pc, inst, reg_write, write_reg, write_data, rd_en,
        input  rd_pc, rd_inst, rd_we, rd_wreg, rd_wdata
    );

    modport slave (
        input  commit_valid, pc, inst, reg_write, write_reg, write_data, rd_en,
        output rd_pc, rd_inst, rd_we, rd_wreg, rd_wdata
    );
endinterface

// File: rtl/cpu_trace_monitor.sv
// Captures retired instructions into a first-word-fall-through trace FIFO while armed,
// stopping on a PC self-loop (halt) or a cycle budget. Define CPU_TRACE_OVERWRITE_EN to overwrite the oldest entry when full.
module cpu_trace_monitor #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned MAX_CYCLES  = 100,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    cpu_trace_if.slave               trc,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [31:0]              retired,
    output logic [31:0]              cycles,
    output logic                     running,
    output logic                     done,
    output logic                     halt_detected,
    output logic                     timeout
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic              we;
        logic [4:0]        wreg;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       retired_q, retired_d;
    logic [31:0]       cycles_q, cycles_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [DATA_W-1:0] last_pc_q, last_pc_d;
    logic              halt_q, halt_d;
    logic              timeout_q, timeout_d;

    entry_t            mem_q [DEPTH];
    entry_t            head_c;
    entry_t            push_entry_c;
    logic              push_c, pop_c, mem_we_c, full_c;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign full_c       = (count_q == CNT_W'(DEPTH));
    assign push_entry_c = '{pc: trc.pc, inst: trc.inst, we: trc.reg_write,
                            wreg: trc.write_reg, wdata: trc.write_data};

    // Next-state: capture FSM, counters, halt detector and FIFO pointers
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        retired_d  = retired_q;
        cycles_d   = cycles_q;
        rep_d      = rep_q;
        last_pc_d  = last_pc_q;
        halt_d     = halt_q;
        timeout_d  = timeout_q;
        push_c     = 1'b0;
        mem_we_c   = 1'b0;
        pop_c      = trc.rd_en && (count_q != '0);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                cycles_d = sat_inc(cycles_q);
                if (cycles_d == 32'(MAX_CYCLES)) timeout_d = 1'b1;
                if (trc.commit_valid) begin
                    push_c    = 1'b1;
                    retired_d = sat_inc(retired_q);
                    last_pc_d = trc.pc;
                    // rep_q == 0 means no earlier commit to compare against
                    rep_d     = ((rep_q != '0) && (trc.pc == last_pc_q)) ? rep_q + REP_W'(1)
                                                                         : REP_W'(1);
                    if (rep_d == REP_W'(HALT_REPEAT)) halt_d = 1'b1;
                end
                if (halt_d || timeout_d) state_d = S_DONE;
            end
            default: begin
            end
        endcase

        if (push_c && pop_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            mem_we_c = 1'b1;
        end else if (push_c && !full_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
            mem_we_c = 1'b1;
        end else if (push_c) begin
            overflow_d = 1'b1;
`ifdef CPU_TRACE_OVERWRITE_EN
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            mem_we_c = 1'b1;
`endif
        end else if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            retired_q  <= '0;
            cycles_q   <= '0;
            rep_q      <= '0;
            last_pc_q  <= '0;
            halt_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            retired_q  <= retired_d;
            cycles_q   <= cycles_d;
            rep_q      <= rep_d;
            last_pc_q  <= last_pc_d;
            halt_q     <= halt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clock) begin
        if (reset && mem_we_c) mem_q[wr_ptr_q] <= push_entry_c;
    end

    assign head_c        = mem_q[rd_ptr_q];
    assign trc.rd_pc     = head_c.pc;
    assign trc.rd_inst   = head_c.inst;
    assign trc.rd_we     = head_c.we;
    assign trc.rd_wreg   = head_c.wreg;
    assign trc.rd_wdata  = head_c.wdata;

    assign empty         = (count_q == '0);
    assign full          = full_c;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign retired       = retired_q;
    assign cycles        = cycles_q;
    assign running       = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign halt_detected = halt_q;
    assign timeout       = timeout_q;
endmodule

// File: doc/cpu_trace_monitor.md
CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning PC/instruction/writeback data width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning trace FIFO entries; must be a power of two, minimum 2.
REQ-003 SHALL have parameter MAX_CYCLES, default 100, meaning RUN-cycle limit before timeout.
REQ-004 SHALL have parameter HALT_REPEAT, default 4, meaning consecutive same-PC commits that declare halt; minimum 2.
REQ-005 SHALL have ports clock in 1 (single clock, all logic on rising edge) and reset in 1 (synchronous, active-low), listed first.
REQ-006 SHALL have inputs start 1 (arm capture), commit_valid 1 (instruction retires this cycle), pc DATA_W, inst DATA_W, reg_write 1, write_reg 5, write_data DATA_W.
REQ-007 SHALL have input rd_en 1, meaning pop the FIFO head.
REQ-008 SHALL have outputs rd_pc DATA_W, rd_inst DATA_W, rd_we 1, rd_wreg 5, rd_wdata DATA_W, meaning the head entry (first-word fall-through).
REQ-009 SHALL have outputs empty 1, full 1, count clog2(DEPTH)+1, overflow 1 (sticky), retired 32, cycles 32, running 1, done 1, halt_detected 1, timeout 1.

Function
REQ-010 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on halt or timeout; DONE held until reset; start ignored outside IDLE.
REQ-011 SHALL assert running only in RUN, done only in DONE.
REQ-012 SHALL, in RUN, increment cycles every clock and retired on every commit_valid; both saturate at 2^32-1.
REQ-013 SHALL, in RUN with commit_valid, push {pc, inst, reg_write, write_reg, write_data} into the FIFO the same edge.
REQ-014 SHALL drive rd_* combinationally from the head entry whenever empty=0; rd_* values are don't-care when empty=1.
REQ-015 SHALL pop one entry per rd_en when empty=0; rd_en with empty=1 SHALL be ignored, no state change.
REQ-016 SHALL accept pop in any state, including IDLE and DONE.
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged, including when full; no overflow in that case.
REQ-018 SHALL, on push with full=1 and no pop, apply the drop/overwrite rule of REQ-026 and set overflow.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-020 SHALL count a halt repeat when a commit's pc equals the previous commit's pc; any differing pc resets the repeat count to 1; halt_detected set when the count reaches HALT_REPEAT.
REQ-021 SHALL set timeout when cycles reaches MAX_CYCLES in RUN.
REQ-022 SHALL, if halt and timeout occur on the same edge, set both flags and enter DONE once.
REQ-023 SHALL capture the commit that triggers halt; no pushes in IDLE or DONE.

Reset
REQ-024 SHALL, on reset=0 at a rising edge, enter IDLE; clear FIFO pointers, count, overflow, retired, cycles, halt repeat count, halt_detected and timeout; outputs empty=1, full=0, running=0, done=0.
REQ-025 SHALL give reset priority over start, commit_valid and rd_en, including mid-RUN; FIFO contents are lost.

Configuration
REQ-026 SHALL, with macro CPU_TRACE_OVERWRITE_EN defined, on push when full, discard the oldest entry and store the new one (count stays DEPTH, head advances); without it, drop the new entry and keep the FIFO unchanged; overflow is set in both cases.

Verification
REQ-027 Reset, start, 3 commits with pc 0x0,0x4,0x8 -> count=3, retired=3; three pops return pc 0x0,0x4,0x8 in order; then empty=1.
REQ-028 DEPTH=16, 18 commits pc 0x0..0x44 step 4, no pops -> full=1, overflow=1; without macro head pc=0x0; with CPU_TRACE_OVERWRITE_EN head pc=0x8.
REQ-029 Commits pc 0x10,0x14,0x14,0x14,0x14 -> halt_detected=1 after 4th 0x14, done=1; 5 entries in FIFO; later commits not captured.
REQ-030 MAX_CYCLES=100, commits with distinct pcs each cycle -> timeout=1 at cycles=100, halt_detected=0, done=1.
REQ-031 FIFO full plus simultaneous commit and rd_en -> count stays 16, overflow stays 0; rd_en on empty -> no change.
REQ-032 Assert reset=0 mid-RUN with count=5 -> next edge state IDLE, count=0, retired=0, cycles=0, all flags 0.
